// File: rtl/branch_predict_unit_pkg.sv
// Types and helpers shared by the branch predictor files.
package branch_predict_unit_pkg;

    // Counter state written into an entry on reset and on allocation.
    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_ALLOC = 2'b10;

    // Kind of conditional branch decoded from the ID opcode.
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_e;

    // Branch outcome from branch kind and operand equality.
    function automatic logic br_taken(input br_kind_e kind, input logic ops_equal);
        logic taken;
        case (kind)
            BR_EQ:   taken = ops_equal;
            BR_NE:   taken = ~ops_equal;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/header.vh
// Shared opcode, width and branch-predictor counter encodings.
`ifndef HEADER_VH
`define HEADER_VH

`define PC_WIDTH     32
`define DWIDTH       32
`define IMM_WIDTH    16
`define OPCODE_WIDTH 6

`define BEQ 6'b000100
`define BNE 6'b000101

`define BP_SNT 2'b00
`define BP_WNT 2'b01
`define BP_WT  2'b10
`define BP_ST  2'b11

`endif

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
`include "header.vh"

module sat_counter2
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next_cnt
);

    // Step up on taken, down on not-taken, holding at both ends.
    always_comb begin
        next_cnt = cnt;
        case (cnt)
            `BP_SNT: next_cnt = taken ? `BP_WNT : `BP_SNT;
            `BP_WNT: next_cnt = taken ? `BP_WT  : `BP_SNT;
            `BP_WT:  next_cnt = taken ? `BP_ST  : `BP_WNT;
            `BP_ST:  next_cnt = taken ? `BP_ST  : `BP_WT;
            default: next_cnt = CNT_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: fetch-stage prediction,
// ID-stage branch resolution/redirect and branch statistics.
`include "header.vh"

module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int PC_WIDTH  = `PC_WIDTH,
    parameter int DWIDTH    = `DWIDTH,
    parameter int IMM_WIDTH = `IMM_WIDTH,
    parameter int BTB_DEPTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [PC_WIDTH-1:0]      i_if_pc,
    output logic                     o_pred_taken,
    output logic [PC_WIDTH-1:0]      o_pred_pc,
    input  logic                     i_branch,
    input  logic [`OPCODE_WIDTH-1:0] i_opcode,
    input  logic [PC_WIDTH-1:0]      i_id_pc,
    input  logic [PC_WIDTH-1:0]      i_pc,
    input  logic [IMM_WIDTH-1:0]     i_imm,
    input  logic [DWIDTH-1:0]        i_data_r1,
    input  logic [DWIDTH-1:0]        i_data_r2,
    input  logic                     i_pred_taken,
    input  logic [PC_WIDTH-1:0]      i_es_o_pc,
    input  logic                     i_es_o_change_pc,
    input  logic                     i_stall,
    output logic [PC_WIDTH-1:0]      o_pc,
    output logic                     o_compare,
    output logic [CNT_WIDTH-1:0]     o_branch_cnt,
    output logic [CNT_WIDTH-1:0]     o_mispredict_cnt
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    // Branch-target buffer state.
    logic                valid_r  [BTB_DEPTH];
    logic [TAG_W-1:0]    tag_r    [BTB_DEPTH];
    logic [PC_WIDTH-1:0] target_r [BTB_DEPTH];
    logic [1:0]          cnt_r    [BTB_DEPTH];

    logic [CNT_WIDTH-1:0] branch_cnt_r;
    logic [CNT_WIDTH-1:0] mispredict_cnt_r;

    // Word-aligned PCs: the two byte-offset bits carry no index/tag info.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{i_if_pc[1:0], i_id_pc[1:0]};

    logic [IDX-1:0]      lk_idx_s;
    logic [TAG_W-1:0]    lk_tag_s;
    logic [IDX-1:0]      up_idx_s;
    logic [TAG_W-1:0]    up_tag_s;
    logic                up_hit_s;
    logic [PC_WIDTH-1:0] target_s;
    br_kind_e            kind_s;
    logic                taken_s;
    logic                mispredict_s;
    logic [1:0]          next_cnt_s;

    assign lk_idx_s = i_if_pc[IDX+1:2];
    assign lk_tag_s = i_if_pc[PC_WIDTH-1:IDX+2];
    assign up_idx_s = i_id_pc[IDX+1:2];
    assign up_tag_s = i_id_pc[PC_WIDTH-1:IDX+2];
    assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

    // Fetch lookup from registered state only; same-cycle updates are not bypassed.
    always_comb begin
        o_pred_taken = 1'b0;
        o_pred_pc    = {PC_WIDTH{1'b0}};
        if (valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s) && cnt_r[lk_idx_s][1]) begin
            o_pred_taken = 1'b1;
            o_pred_pc    = target_r[lk_idx_s];
        end else begin
            o_pred_taken = 1'b0;
            o_pred_pc    = {PC_WIDTH{1'b0}};
        end
    end

    // Decode the ID opcode into a branch kind.
    always_comb begin
        kind_s = BR_NONE;
        if (i_opcode == `BEQ) begin
            kind_s = BR_EQ;
        end else if (i_opcode == `BNE) begin
            kind_s = BR_NE;
        end else begin
            kind_s = BR_NONE;
        end
    end

    assign target_s     = i_pc + {{(PC_WIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
    assign taken_s      = br_taken(kind_s, i_data_r1 == i_data_r2);
    assign mispredict_s = taken_s != i_pred_taken;

    // Redirect select: ID branch correction, else the execute-stage redirect.
    always_comb begin
        o_compare = 1'b0;
        o_pc      = {PC_WIDTH{1'b0}};
        if (i_branch) begin
            if (mispredict_s) begin
                o_compare = 1'b1;
                o_pc      = taken_s ? target_s : i_pc;
            end else begin
                o_compare = 1'b0;
                o_pc      = {PC_WIDTH{1'b0}};
            end
        end else begin
            o_compare = i_es_o_change_pc;
            o_pc      = i_es_o_pc;
        end
    end

    // One counter-update datapath shared by all entries at the update port.
    sat_counter2 u_sat_counter2 (
        .cnt      (cnt_r[up_idx_s]),
        .taken    (taken_s),
        .next_cnt (next_cnt_s)
    );

    // BTB update: train on hit, allocate on taken miss; reset wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {PC_WIDTH{1'b0}};
                cnt_r[i]    <= CNT_RESET;
            end
        end else if (i_branch && !i_stall) begin
            if (up_hit_s) begin
                cnt_r[up_idx_s]    <= next_cnt_s;
                target_r[up_idx_s] <= target_s;
            end else if (taken_s) begin
                valid_r[up_idx_s]  <= 1'b1;
                tag_r[up_idx_s]    <= up_tag_s;
                target_r[up_idx_s] <= target_s;
                cnt_r[up_idx_s]    <= CNT_ALLOC;
            end
        end
    end

    // Saturating branch and mispredict statistics, frozen while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            branch_cnt_r     <= {CNT_WIDTH{1'b0}};
            mispredict_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (i_branch && !i_stall) begin
            if (branch_cnt_r != {CNT_WIDTH{1'b1}}) begin
                branch_cnt_r <= branch_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (mispredict_s && (mispredict_cnt_r != {CNT_WIDTH{1'b1}})) begin
                mispredict_cnt_r <= mispredict_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_branch_cnt     = branch_cnt_r;
    assign o_mispredict_cnt = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit with hand-computed expectations.
module tb_branch_predict_unit;

    localparam int PC_WIDTH  = 32;
    localparam int DWIDTH    = 32;
    localparam int IMM_WIDTH = 16;
    localparam int BTB_DEPTH = 16;
    localparam int CNT_WIDTH = 16;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic [PC_WIDTH-1:0]  i_if_pc;
    logic                 o_pred_taken;
    logic [PC_WIDTH-1:0]  o_pred_pc;
    logic                 i_branch;
    logic [5:0]           i_opcode;
    logic [PC_WIDTH-1:0]  i_id_pc;
    logic [PC_WIDTH-1:0]  i_pc;
    logic [IMM_WIDTH-1:0] i_imm;
    logic [DWIDTH-1:0]    i_data_r1;
    logic [DWIDTH-1:0]    i_data_r2;
    logic                 i_pred_taken;
    logic [PC_WIDTH-1:0]  i_es_o_pc;
    logic                 i_es_o_change_pc;
    logic                 i_stall;
    logic [PC_WIDTH-1:0]  o_pc;
    logic                 o_compare;
    logic [CNT_WIDTH-1:0] o_branch_cnt;
    logic [CNT_WIDTH-1:0] o_mispredict_cnt;

    int checks   = 0;
    int failures = 0;

    branch_predict_unit #(
        .PC_WIDTH  (PC_WIDTH),
        .DWIDTH    (DWIDTH),
        .IMM_WIDTH (IMM_WIDTH),
        .BTB_DEPTH (BTB_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_if_pc          (i_if_pc),
        .o_pred_taken     (o_pred_taken),
        .o_pred_pc        (o_pred_pc),
        .i_branch         (i_branch),
        .i_opcode         (i_opcode),
        .i_id_pc          (i_id_pc),
        .i_pc             (i_pc),
        .i_imm            (i_imm),
        .i_data_r1        (i_data_r1),
        .i_data_r2        (i_data_r2),
        .i_pred_taken     (i_pred_taken),
        .i_es_o_pc        (i_es_o_pc),
        .i_es_o_change_pc (i_es_o_change_pc),
        .i_stall          (i_stall),
        .o_pc             (o_pc),
        .o_compare        (o_compare),
        .o_branch_cnt     (o_branch_cnt),
        .o_mispredict_cnt (o_mispredict_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then settle 1 time unit later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_branch(input logic [5:0] op, input logic [31:0] id_pc,
                                input logic [31:0] pc, input logic [15:0] imm,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic pred);
        i_branch     = 1'b1;
        i_opcode     = op;
        i_id_pc      = id_pc;
        i_pc         = pc;
        i_imm        = imm;
        i_data_r1    = r1;
        i_data_r2    = r2;
        i_pred_taken = pred;
        #1;
    endtask

    task automatic idle();
        i_branch     = 1'b0;
        i_opcode     = 6'd0;
        i_pred_taken = 1'b0;
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_pc);
        i_if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, o_pred_taken}, {31'd0, exp_taken});
        check({tag, "_pc"}, o_pred_pc, exp_pc);
    endtask

    task automatic check_redirect(input string tag, input logic exp_cmp, input logic [31:0] exp_pc);
        check({tag, "_cmp"}, {31'd0, o_compare}, {31'd0, exp_cmp});
        check({tag, "_pc"}, o_pc, exp_pc);
    endtask

    task automatic check_stats(input string tag, input int exp_br, input int exp_mp);
        check({tag, "_br"}, {16'd0, o_branch_cnt}, exp_br);
        check({tag, "_mp"}, {16'd0, o_mispredict_cnt}, exp_mp);
    endtask

    initial begin
        i_rst = 1'b1; i_if_pc = 32'd0; i_branch = 1'b0; i_opcode = 6'd0;
        i_id_pc = 32'd0; i_pc = 32'd0; i_imm = 16'd0; i_data_r1 = 32'd0;
        i_data_r2 = 32'd0; i_pred_taken = 1'b0; i_es_o_pc = 32'd0;
        i_es_o_change_pc = 1'b0; i_stall = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        lookup("rst_lk40", 32'h40, 1'b0, 32'h0);
        lookup("rst_lk1234", 32'h1234, 1'b0, 32'h0);
        check_stats("rst", 0, 0);

        // BEQ taken, miss -> allocate; same-cycle lookup sees the empty entry
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd5, 32'd5, 1'b0);
        check_redirect("beq_alloc", 1'b1, 32'h54);
        lookup("alloc_nobypass", 32'h40, 1'b0, 32'h0);
        tick();
        idle();
        check_redirect("idle", 1'b0, 32'h0);
        lookup("alloc_lk", 32'h40, 1'b1, 32'h54);
        check_stats("alloc", 1, 1);

        // Not taken, predicted taken: 10 -> 01
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd5, 32'd6, 1'b1);
        check_redirect("nt1", 1'b1, 32'h44);
        tick();
        idle();
        lookup("nt1_lk", 32'h40, 1'b0, 32'h0);
        // Not taken, predicted not taken: 01 -> 00, no redirect
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd5, 32'd6, 1'b0);
        check_redirect("nt2", 1'b0, 32'h0);
        tick();
        // Not taken again: stays 00
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd5, 32'd6, 1'b0);
        tick();
        // Taken: 00 -> 01, still not predicted (proves saturation at 00)
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd9, 32'd9, 1'b0);
        check_redirect("t1", 1'b1, 32'h54);
        tick();
        idle();
        lookup("sat_lk", 32'h40, 1'b0, 32'h0);
        // Taken: 01 -> 10, predicted again
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd9, 32'd9, 1'b0);
        tick();
        idle();
        lookup("retrain_lk", 32'h40, 1'b1, 32'h54);
        check_stats("train", 6, 4);

        // BNE with equal operands predicted taken: falls through, miss -> no write
        drive_branch(OP_BNE, 32'h80, 32'h84, 16'h0020, 32'd7, 32'd7, 1'b1);
        check_redirect("bne", 1'b1, 32'h84);
        tick();
        idle();
        lookup("bne_lk80", 32'h80, 1'b0, 32'h0);
        lookup("bne_lk40", 32'h40, 1'b1, 32'h54);
        check_stats("bne", 7, 5);

        // Execute-stage redirect passes through when no branch is in ID
        i_es_o_change_pc = 1'b1;
        i_es_o_pc        = 32'h200;
        #1;
        check_redirect("es", 1'b1, 32'h200);
        i_es_o_change_pc = 1'b0;
        i_es_o_pc        = 32'h0;

        // Stalled resolve: redirect still shown, no state change
        i_stall = 1'b1;
        drive_branch(OP_BEQ, 32'hC0, 32'hC4, 16'h0008, 32'd1, 32'd1, 1'b0);
        check_redirect("stall", 1'b1, 32'hCC);
        tick();
        i_stall = 1'b0;
        idle();
        lookup("stall_lkC0", 32'hC0, 1'b0, 32'h0);
        lookup("stall_lk40", 32'h40, 1'b1, 32'h54);
        check_stats("stall", 7, 5);

        // Aliasing with negative offset: 0x80 evicts 0x40; same-cycle lookup sees old entry
        drive_branch(OP_BEQ, 32'h80, 32'h84, 16'hFFF0, 32'd3, 32'd3, 1'b0);
        check_redirect("alias", 1'b1, 32'h74);
        lookup("alias_old", 32'h40, 1'b1, 32'h54);
        tick();
        idle();
        lookup("alias_new", 32'h80, 1'b1, 32'h74);
        lookup("alias_evicted", 32'h40, 1'b0, 32'h0);
        check_stats("alias", 8, 6);

        // Reset overrides a concurrent update
        i_rst = 1'b1;
        drive_branch(OP_BEQ, 32'h40, 32'h44, 16'h0010, 32'd5, 32'd5, 1'b0);
        tick();
        i_rst = 1'b0;
        idle();
        lookup("rst2_lk80", 32'h80, 1'b0, 32'h0);
        lookup("rst2_lk40", 32'h40, 1'b0, 32'h0);
        check_stats("rst2", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL take parameter PC_WIDTH, default `PC_WIDTH, program-counter width.
REQ-002 SHALL take parameter DWIDTH, default `DWIDTH, register data width.
REQ-003 SHALL take parameter IMM_WIDTH, default `IMM_WIDTH, branch immediate width.
REQ-004 SHALL take parameter BTB_DEPTH, default 16, branch-target-buffer entries, power of two, at least 2.
REQ-005 SHALL take parameter CNT_WIDTH, default 16, statistics counter width.
REQ-006 i_clk  input  1  sole clock, all state on rising edge.
REQ-007 i_rst  input  1  reset, synchronous and active-high.
REQ-008 i_if_pc  input  PC_WIDTH  fetch-stage PC to predict.
REQ-009 o_pred_taken  output  1  fetch prediction: taken.
REQ-010 o_pred_pc  output  PC_WIDTH  predicted target, valid when o_pred_taken=1.
REQ-011 i_branch  input  1  ID-stage instruction is a conditional branch.
REQ-012 i_opcode  input  `OPCODE_WIDTH  ID opcode, BEQ or BNE.
REQ-013 i_id_pc  input  PC_WIDTH  address of the ID branch; used for index and tag.
REQ-014 i_pc  input  PC_WIDTH  sequential successor PC of the ID branch.
REQ-015 i_imm  input  IMM_WIDTH  branch offset.
REQ-016 i_data_r1, i_data_r2  input  DWIDTH each  forwarded operands.
REQ-017 i_pred_taken  input  1  prediction carried down the pipe with the ID instruction.
REQ-018 i_es_o_pc, i_es_o_change_pc  input  PC_WIDTH, 1  execute-stage redirect (jr/jal).
REQ-019 i_stall  input  1  pipeline stall; freezes all updates.
REQ-020 o_pc, o_compare  output  PC_WIDTH, 1  redirect target and redirect-valid.
REQ-021 o_branch_cnt, o_mispredict_cnt  output  CNT_WIDTH each  statistics.

Function
REQ-022 Index: IDX = log2(BTB_DEPTH) bits, i_if_pc[IDX+1:2] for lookup and i_id_pc[IDX+1:2] for update. Tag: remaining upper PC bits.
REQ-023 Entry: valid bit, tag, target (PC_WIDTH), 2-bit saturating counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-024 Lookup is combinational from registered state. o_pred_taken=1 only when the entry is valid, the tag matches, and counter[1]=1. Otherwise o_pred_taken=0 and o_pred_pc=0.
REQ-025 Resolve when i_branch=1:
- target = i_pc + sign-extended i_imm, width-truncated to PC_WIDTH.
- taken = (BEQ and r1==r2) or (BNE and r1!=r2). Any other opcode is not taken.
REQ-026 Mispredict = taken != i_pred_taken. On mispredict: o_compare=1; o_pc = target if taken, else i_pc. Otherwise o_compare=0 and o_pc=0.
REQ-027 When i_branch=0: o_compare=i_es_o_change_pc and o_pc=i_es_o_pc. A branch in ID never sees an ES redirect in the same cycle, so the pipeline guarantees no conflict.
REQ-028 Update happens on the edge after resolve, if i_branch=1 and i_stall=0:
- Hit: counter +1 if taken, -1 if not; saturate at 11 and 00; store the target.
- Miss and taken: allocate the entry with valid=1, new tag, target, counter=10.
- Miss and not taken: no write.
REQ-029 If lookup and update hit the same index in the same cycle, the lookup returns the pre-update entry (no bypass).
REQ-030 o_branch_cnt increments per resolved branch; o_mispredict_cnt increments per mispredict. Both saturate at all-ones and are gated by i_stall.
REQ-031 Redirect outputs are combinational, so redirect latency is 0 cycles. They are not gated by i_stall.

Reset
REQ-032 When i_rst=1 at an edge:
- All valid bits and both statistics counters clear to 0.
- All counters set to 01.
- Targets and tags clear to 0.
REQ-033 Reset overrides any same-cycle update. Output values in the reset cycle follow the cleared state from the next cycle.

Structure
REQ-034 The following SHALL live in header.vh:
- BEQ and BNE opcodes.
- `PC_WIDTH, `DWIDTH, `IMM_WIDTH and `OPCODE_WIDTH.
- New `BP_SNT, `BP_WNT, `BP_WT and `BP_ST counter encodings.
REQ-035 The next-state counter logic SHALL be one sub-module, sat_counter2, instantiated per entry or shared at the update port.

Verification
REQ-036 Reset, then lookup any PC -> o_pred_taken=0 and o_pred_pc=0; both statistics counters = 0.
REQ-037 BEQ at i_id_pc=0x40, i_pc=0x44, imm=0x10, r1=r2=5, i_pred_taken=0 -> o_compare=1, o_pc=0x54. Next cycle, lookup 0x40 -> o_pred_taken=1, o_pred_pc=0x54. Both statistics counters = 1.
REQ-038 Same branch resolves not-taken twice after allocation -> counter goes 10, 01, 00. Lookup then predicts not-taken. A third not-taken gives a counter still at 00.
REQ-039 BNE with r1=r2, i_pred_taken=1, i_pc=0x84 -> o_compare=1, o_pc=0x84; o_mispredict_cnt increments.
REQ-040 i_branch=0, i_es_o_change_pc=1, i_es_o_pc=0x200 -> o_compare=1, o_pc=0x200. With i_stall=1 during a resolved branch -> no table or statistics change.
REQ-041 Aliasing: PCs 0x40 and 0x40+4*BTB_DEPTH -> the second allocation evicts the first, and the first then misses. Same-index lookup and update in one cycle -> the old value is returned.
